// File: rtl/rcc_div_ratio_ctrl.sv
// Divider ratio update controller: accepts a new ratio, lets the divider settle,
// then waits for the synchronized enable feedback to match before signalling done.
module rcc_div_ratio_ctrl #(
    parameter int RATIO_WID   = 8,
    parameter int RST_RATIO   = 1,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 i_clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    input  logic [RATIO_WID-1:0] req_ratio,
    output logic                 req_ready,
    output logic [RATIO_WID-1:0] ratio,
    input  logic                 div_en,
    output logic                 busy,
    output logic                 done,
    output logic                 done_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        WAIT_EN = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [RATIO_WID-1:0] RATIO_RST    = RATIO_WID'(RST_RATIO);
    localparam logic [15:0]          SETTLE_LD    = 16'(SETTLE_CYC - 1);
    localparam logic [15:0]          TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0]          CNT_MAX      = 16'hFFFF;

    state_t               state, state_nxt;
    logic [15:0]          cnt, cnt_nxt;
    logic                 err, err_nxt;
    logic [RATIO_WID-1:0] ratio_nxt;
    logic                 en_meta, en_s;
    logic                 en_exp;

    // div_en comes from the divider's clock domain; two flops before any use.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            en_meta <= 1'b0;
            en_s    <= 1'b0;
        end else begin
            en_meta <= div_en;
            en_s    <= en_meta;
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            err   <= 1'b0;
            ratio <= RATIO_RST;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            err   <= err_nxt;
            ratio <= ratio_nxt;
        end
    end

    assign en_exp = (ratio != '0);

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err;
        ratio_nxt = ratio;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    err_nxt = 1'b0;
                    if (req_ratio != ratio) begin
                        ratio_nxt = req_ratio;
                        cnt_nxt   = SETTLE_LD;
                        state_nxt = SETTLE;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = WAIT_EN;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            WAIT_EN: begin
                // A match wins over a timeout landing in the same cycle.
                if (en_s == en_exp) begin
                    err_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else if (cnt == TIMEOUT_LAST) begin
                    err_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        done_err  = 1'b0;
        if (state == IDLE) begin
            req_ready = 1'b1;
            busy      = 1'b0;
        end
        if (state == DONE) begin
            done     = 1'b1;
            done_err = err;
        end
    end

endmodule

// File: tb/tb_rcc_div_ratio_ctrl.sv
// Randomized bench for rcc_div_ratio_ctrl; a transaction-level model predicts
// the done cycle and error flag of each request from the div_en waveform plan.
module tb_rcc_div_ratio_ctrl;

    localparam int RATIO_WID   = 8;
    localparam int RST_RATIO   = 1;
    localparam int SETTLE_CYC  = 4;
    localparam int TIMEOUT_CYC = 64;

    logic                 i_clk;
    logic                 rst_n;
    logic                 req_valid;
    logic [RATIO_WID-1:0] req_ratio;
    logic                 req_ready;
    logic [RATIO_WID-1:0] ratio;
    logic                 div_en;
    logic                 busy;
    logic                 done;
    logic                 done_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [RATIO_WID-1:0] model_ratio;

    rcc_div_ratio_ctrl #(
        .RATIO_WID  (RATIO_WID),
        .RST_RATIO  (RST_RATIO),
        .SETTLE_CYC (SETTLE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .i_clk    (i_clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ratio(req_ratio),
        .req_ready(req_ready),
        .ratio    (ratio),
        .div_en   (div_en),
        .busy     (busy),
        .done     (done),
        .done_err (done_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // div_en plan relative to the accept edge: v0 before offset sw, v1 from sw on.
    // en_s seen in cycle k is the div_en driven two cycles earlier.
    function automatic void predict(input bit changed, input logic [RATIO_WID-1:0] r,
                                    input bit v0, input bit v1, input int sw,
                                    output int d, output bit e);
        bit want;
        bit en;
        int k;
        if (!changed) begin
            d = 0;
            e = 1'b0;
            return;
        end
        want = (r != 0);
        d = SETTLE_CYC + TIMEOUT_CYC;
        e = 1'b1;
        for (int j = 0; j < TIMEOUT_CYC; j++) begin
            k  = SETTLE_CYC + j;
            en = ((k - 2) < sw) ? v0 : v1;
            if (en == want) begin
                d = k + 1;
                e = 1'b0;
                break;
            end
        end
    endfunction

    // Entered just after a rising edge with the DUT idle; returns just after
    // the edge that ends the done cycle.
    task automatic run_txn(input logic [RATIO_WID-1:0] r, input bit v0, input bit v1, input int sw);
        bit changed;
        int d;
        bit e;
        changed = (r != model_ratio);
        predict(changed, r, v0, v1, sw, d, e);
        req_valid = 1'b1;
        req_ratio = r;
        div_en    = v0;
        @(negedge i_clk);
        check("ready_idle", req_ready, 1'b1);
        check("ratio_pre", ratio, model_ratio);
        model_ratio = r;
        for (int k = 0; k <= d; k++) begin
            @(posedge i_clk);
            #1;
            div_en    = (k < sw) ? v0 : v1;
            req_valid = 1'($urandom_range(0, 1));
            req_ratio = RATIO_WID'($urandom);
            @(negedge i_clk);
            check("busy", busy, 1'b1);
            check("ready_busy", req_ready, 1'b0);
            check("ratio", ratio, model_ratio);
            check("done", done, (k == d));
            check("done_err", done_err, (k == d) ? e : 1'b0);
        end
        @(posedge i_clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic reset_mid_settle(input logic [RATIO_WID-1:0] r_in);
        logic [RATIO_WID-1:0] r;
        r = (r_in == model_ratio) ? (r_in ^ 8'h80) : r_in;
        req_valid = 1'b1;
        req_ratio = r;
        div_en    = 1'b1;
        @(posedge i_clk);
        #1;
        req_valid = 1'b0;
        @(posedge i_clk);
        #3;
        check("rst_pre_ratio", ratio, r);
        check("rst_pre_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        model_ratio = RATIO_WID'(RST_RATIO);
        check("rst_mid_ratio", ratio, model_ratio);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_ready", req_ready, 1'b1);
        check("rst_mid_done", done, 1'b0);
        repeat (3) begin
            @(negedge i_clk);
            check("rst_hold_done", done, 1'b0);
            check("rst_hold_ratio", ratio, model_ratio);
        end
        @(posedge i_clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [RATIO_WID-1:0] r;
        int pick;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_ratio = '0;
        div_en    = 1'b0;
        model_ratio = RATIO_WID'(RST_RATIO);
        #12;
        check("reset_ratio", ratio, RST_RATIO);
        check("reset_ready", req_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_done_err", done_err, 1'b0);
        @(posedge i_clk);
        #1;
        rst_n = 1'b1;

        // Same ratio as reset value, accepted on the first edge after release.
        run_txn(8'd1, 1'b1, 1'b1, 0);
        // Ratio 4 with enable already high.
        run_txn(8'd4, 1'b1, 1'b1, 0);
        // Ratio 0 with div_en falling 3 cycles into WAIT_EN.
        run_txn(8'd0, 1'b1, 1'b0, SETTLE_CYC + 3);
        // Ratio 5 with div_en stuck low: timeout.
        run_txn(8'd5, 1'b0, 1'b0, 0);
        // Feedback arriving on the very last WAIT_EN cycle.
        run_txn(8'd9, 1'b0, 1'b1, SETTLE_CYC + TIMEOUT_CYC - 3);
        // Feedback arriving one cycle too late.
        run_txn(8'd12, 1'b0, 1'b1, SETTLE_CYC + TIMEOUT_CYC - 2);

        reset_mid_settle(8'd7);
        run_txn(8'd3, 1'b1, 1'b1, 0);

        for (int t = 0; t < 40; t++) begin
            pick = $urandom_range(0, 99);
            if (pick < 25)      r = model_ratio;
            else if (pick < 40) r = '0;
            else                r = RATIO_WID'($urandom);
            run_txn(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, SETTLE_CYC + TIMEOUT_CYC + 4));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge i_clk);
                    check("idle_ready", req_ready, 1'b1);
                    check("idle_ratio", ratio, model_ratio);
                    @(posedge i_clk);
                    #1;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
